waveform_shaper: RTL and testbench



---
 rtl/waveform_shaper.sv | 140 ++++++++++++++
 tb/tb_waveform_shaper.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/waveform_shaper.sv
// Purpose: turns the phase accumulator's count/expire pair into saw, square, triangle or sine samples scaled by a gain.
// Latency: 3 cycles from input slot to o_sample, 1 sample per cycle.
// Backpressure: none; every slot is accepted and i_en only marks whether it is valid.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_phase/i_expire/i_en phase slot from the accumulator;
//        i_wave_sel/i_amp/i_load requested shape, gain and immediate-apply strobe;
//        o_sample/o_valid/o_period_start/o_active_sel shaped sample, its qualifiers and the shape in use.
module waveform_shaper #(
  parameter int    DEPTH    = 128,
  parameter int    DATA_W   = 12,
  parameter int    AMP_W    = 8,
  parameter string LUT_FILE = "sine_quarter.mem"
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [$clog2(DEPTH)-1:0]   i_phase,
  input  logic                       i_expire,
  input  logic                       i_en,
  input  logic [1:0]                 i_wave_sel,
  input  logic [AMP_W-1:0]           i_amp,
  input  logic                       i_load,
  output logic signed [DATA_W-1:0]   o_sample,
  output logic                       o_valid,
  output logic                       o_period_start,
  output logic [1:0]                 o_active_sel
);

  localparam int N      = $clog2(DEPTH);
  localparam int Q      = DEPTH / 4;
  localparam int PROD_W = DATA_W + AMP_W + 1;

  // Quarter-wave magnitudes round((2^(DATA_W-1)-1)*sin(2*pi*(k+0.5)/DEPTH)); same contents as the
  // LUT_FILE image, held as a constant table so the ROM needs no load-time initialisation.
  localparam int SINE_Q [Q] = '{
      50,  151,  251,  350,  449,  546,  642,  737,
     830,  920, 1009, 1095, 1179, 1259, 1337, 1411,
    1483, 1550, 1614, 1674, 1729, 1781, 1828, 1871,
    1910, 1944, 1973, 1997, 2017, 2032, 2041, 2046
  };

  // Stage 1. s1_sel/s1_amp double as the shadow (active) select and gain.
  logic [N-1:0]     s1_phase;
  logic             s1_en;
  logic             s1_start;
  logic [1:0]       s1_sel;
  logic [AMP_W-1:0] s1_amp;

  // Stage 2
  logic signed [DATA_W-1:0] s2_w;
  logic                     s2_en;
  logic                     s2_start;
  logic [1:0]               s2_sel;
  logic [AMP_W-1:0]         s2_amp;

  logic             shadow_upd;
  logic [1:0]       sel_nxt;
  logic [AMP_W-1:0] amp_nxt;

  // The update lands in the same slot that carries it, so the new shape applies to that sample.
  always_comb begin
    shadow_upd = i_en & (i_expire | i_load);
    sel_nxt    = shadow_upd ? i_wave_sel : s1_sel;
    amp_nxt    = shadow_upd ? i_amp : s1_amp;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_phase <= '0;
      s1_en    <= 1'b0;
      s1_start <= 1'b0;
      s1_sel   <= '0;
      s1_amp   <= '1;
    end else begin
      s1_phase <= i_phase;
      s1_en    <= i_en;
      s1_start <= i_expire & i_en;
      s1_sel   <= sel_nxt;
      s1_amp   <= amp_nxt;
    end
  end

  logic [N-2:0]             tri_t;
  logic [N-3:0]             sin_k;
  logic [DATA_W-2:0]        sin_m;
  logic signed [DATA_W-1:0] wave;

  always_comb begin
    tri_t = s1_phase[N-1] ? ~s1_phase[N-2:0] : s1_phase[N-2:0];
    // Odd quarters read the table backwards; the top phase bit picks the sign.
    sin_k = s1_phase[N-2] ? ~s1_phase[N-3:0] : s1_phase[N-3:0];
    sin_m = (DATA_W-1)'(SINE_Q[sin_k]);
    wave  = '0;
    case (s1_sel)
      2'd0:    wave = {~s1_phase[N-1], s1_phase[N-2:0], {(DATA_W-N){1'b0}}};
      2'd1:    wave = s1_phase[N-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      2'd2:    wave = {~tri_t[N-2], tri_t[N-3:0], {(DATA_W-N+1){1'b0}}};
      default: wave = s1_phase[N-1] ? -$signed({1'b0, sin_m}) : $signed({1'b0, sin_m});
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_w     <= '0;
      s2_en    <= 1'b0;
      s2_start <= 1'b0;
      s2_sel   <= '0;
      s2_amp   <= '1;
    end else begin
      s2_w     <= wave;
      s2_en    <= s1_en;
      s2_start <= s1_start;
      s2_sel   <= s1_sel;
      s2_amp   <= s1_amp;
    end
  end

  // Gain is amp+1, so the product magnitude never exceeds 2^(DATA_W-1+AMP_W) and the
  // arithmetic shift always lands back inside DATA_W without saturation.
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] gain_ext;

  always_comb begin
    w_ext    = PROD_W'(s2_w);
    gain_ext = PROD_W'(s2_amp) + PROD_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sample       <= '0;
      o_valid        <= 1'b0;
      o_period_start <= 1'b0;
      o_active_sel   <= '0;
    end else begin
      o_sample       <= s2_en ? DATA_W'((w_ext * gain_ext) >>> AMP_W) : '0;
      o_valid        <= s2_en;
      o_period_start <= s2_start;
      o_active_sel   <= s2_sel;
    end
  end

endmodule

// File: tb/tb_waveform_shaper.sv
// Bench for waveform_shaper: directed phase sweeps per waveform, gain, boundary/load switching,
// enable gaps and a mid-stream reset, checked through an expected-result queue.
module tb_waveform_shaper;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [6:0]        phase;
  logic              expire;
  logic              en;
  logic [1:0]        wave_sel;
  logic [7:0]        amp;
  logic              load;
  logic signed [11:0] sample;
  logic              valid;
  logic              period_start;
  logic [1:0]        active_sel;

  waveform_shaper dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_phase        (phase),
    .i_expire       (expire),
    .i_en           (en),
    .i_wave_sel     (wave_sel),
    .i_amp          (amp),
    .i_load         (load),
    .o_sample       (sample),
    .o_valid        (valid),
    .o_period_start (period_start),
    .o_active_sel   (active_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               vld;
    logic signed [11:0] smp;
    logic               st;
    logic [1:0]         sel;
    int                 amp;
    int                 ph;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic [1:0] m_sel;
  int         m_amp;

  // Values stated outright for specific (sel, amp, phase) points.
  localparam int SPOT [16][4] = '{
    '{0, 255,   0, -2048}, '{0, 255,  64,     0}, '{0, 255, 127,  2016},
    '{2, 255,   0, -2048}, '{2, 255,  63,  1984}, '{2, 255,  64,  1984}, '{2, 255, 127, -2048},
    '{3, 255,   0,    50}, '{3, 255,  31,  2046}, '{3, 255,  32,  2046}, '{3, 255,  96, -2046},
    '{3, 255, 127,   -50},
    '{1, 127,  10,  1023}, '{1, 127,  70, -1024}, '{1,   0,  10,     7}, '{1,   0,  70,    -8}
  };

  localparam int SINE_PH [15] = '{0, 1, 2, 8, 10, 20, 31, 32, 40, 63, 64, 72, 96, 105, 127};

  function automatic int wave_model(input int sel, input int p);
    real x;
    case (sel)
      0:       return p * 32 - 2048;
      1:       return (p < 64) ? 2047 : -2048;
      2:       return (p < 64) ? p * 64 - 2048 : (127 - p) * 64 - 2048;
      default: begin
        x = 2047.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 128.0);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
      end
    endcase
  endfunction

  function automatic int scale(input int w, input int a);
    int prod;
    prod = w * (a + 1);
    return prod >>> 8;
  endfunction

  function automatic bit spot(input int sel, input int a, input int p, output int val);
    val = 0;
    for (int i = 0; i < 16; i++) begin
      if (SPOT[i][0] == sel && SPOT[i][1] == a && SPOT[i][2] == p) begin
        val = SPOT[i][3];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] expv);
    checks++;
    assert (act === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, expv);
    end
  endtask

  task automatic push_bubbles();
    exp_t e;
    e.vld = 1'b0; e.smp = '0; e.st = 1'b0; e.sel = 2'd0; e.amp = 255; e.ph = 0;
    sbq.push_back(e);
    sbq.push_back(e);
  endtask

  task automatic step(input bit s_en, input int p, input bit s_exp, input int s_sel,
                      input int s_amp, input bit s_load);
    exp_t e;
    int   sv;
    en       = s_en;
    phase    = 7'(p);
    expire   = s_exp;
    wave_sel = 2'(s_sel);
    amp      = 8'(s_amp);
    load     = s_load;
    if (s_en && (s_exp || s_load)) begin
      m_sel = 2'(s_sel);
      m_amp = s_amp;
    end
    e.vld = s_en;
    e.st  = s_en & s_exp;
    e.sel = m_sel;
    e.amp = m_amp;
    e.ph  = p;
    e.smp = s_en ? 12'(scale(wave_model(int'(m_sel), p), m_amp)) : 12'sd0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      chk("valid", 32'(valid), 32'(e.vld));
      chk("sample", 32'(sample), 32'(e.smp));
      chk("period_start", 32'(period_start), 32'(e.st));
      chk("active_sel", 32'(active_sel), 32'(e.sel));
      if (e.vld && spot(int'(e.sel), e.amp, e.ph, sv))
        chk($sformatf("spot_sel%0d_amp%0d_ph%0d", e.sel, e.amp, e.ph), 32'(sample), sv);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; phase = '0; expire = 1'b0;
    wave_sel = '0; amp = '0; load = 1'b0;
    m_sel = 2'd0; m_amp = 255;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample", 32'(sample), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_period_start", 32'(period_start), 0);
    chk("rst_active_sel", 32'(active_sel), 0);
    rst_n = 1'b1;
    push_bubbles();

    // Sawtooth, unity gain
    for (int p = 0; p < 128; p++) step(1'b1, p, p == 0, 0, 255, 1'b0);
    // Request square at phase 20 without load: must wait for the next period
    for (int p = 0; p < 128; p++) step(1'b1, p, p == 0, (p >= 20) ? 1 : 0, 255, 1'b0);
    // Square, half gain, then minimum gain
    for (int p = 0; p < 128; p++) step(1'b1, p, p == 0, 1, 127, 1'b0);
    for (int p = 0; p < 128; p++) step(1'b1, p, p == 0, 1, 0, 1'b0);
    // Triangle
    for (int p = 0; p < 128; p++) step(1'b1, p, p == 0, 2, 255, 1'b0);
    // Sine at selected phases
    foreach (SINE_PH[i]) step(1'b1, SINE_PH[i], SINE_PH[i] == 0, 3, 255, 1'b0);
    // Saw, then immediate load of square at phase 20
    for (int p = 0; p <= 40; p++) step(1'b1, p, p == 0, (p >= 20) ? 1 : 0, 255, p == 20);
    // Expire and load together, sine at amp 200
    for (int p = 0; p < 32; p++) step(1'b1, p, p == 0, 3, 200, p == 0);
    // Invalid slots carrying update requests must change nothing
    step(1'b0, 0, 1'b1, 2, 17, 1'b1);
    step(1'b0, 0, 1'b1, 2, 17, 1'b1);
    for (int p = 32; p <= 40; p++) step(1'b1, p, 1'b0, 3, 200, 1'b0);

    // Mid-stream reset: outputs clear without waiting for a clock
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sample", 32'(sample), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_period_start", 32'(period_start), 0);
    chk("mid_rst_active_sel", 32'(active_sel), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    m_sel = 2'd0;
    m_amp = 255;
    push_bubbles();

    step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    // Triangle requested but no boundary yet: reset-state saw at unity gain
    for (int p = 5; p <= 7; p++) step(1'b1, p, 1'b0, 2, 100, 1'b0);
    step(1'b1, 0, 1'b1, 2, 255, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
